// File: rtl/alu_op_sequencer.sv
// Purpose : sequences one register-level ALU command through ALU_REG (load A, load B, capture F, write back).
// Latency : accept edge in cycle 0, done pulse in cycle 4, result readable on dbg_data from cycle 5.
// Backpr. : cmd_ready is low for the whole 5-cycle sequence; cmd_valid while busy is ignored, nothing queues.
//
// Ports:
//   clk, rst_n                       shared clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_op/rs1/rs2/rd/imm_en/imm     command fields, sampled only on the accept edge
//   ALU_OP, Data_A, Data_B           op and operands presented to ALU_REG
//   ld_A, ld_B, ld_F                 ALU_REG load enables, one cycle each
//   F, FR                            registered result and flags returned by ALU_REG
//   done, flags                      writeback pulse and flags captured at that writeback
//   busy                             high in every state except IDLE
//   dbg_addr/dbg_data                combinational register-file read port
module alu_op_sequencer #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [AW-1:0] cmd_rd,
  input  logic          cmd_imm_en,
  input  logic [DW-1:0] cmd_imm,

  output logic [3:0]    ALU_OP,
  output logic [DW-1:0] Data_A,
  output logic [DW-1:0] Data_B,
  output logic          ld_A,
  output logic          ld_B,
  output logic          ld_F,
  input  logic [DW-1:0] F,
  input  logic [3:0]    FR,

  output logic          done,
  output logic [3:0]    flags,
  output logic          busy,

  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int NREG = 1 << AW;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_A = 3'd1,
    LD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  // Fields of the in-flight command still needed after the accept edge.
  // The op lives directly in ALU_OP and the A operand in Data_A, both of
  // which are captured on the accept edge itself.
  typedef struct packed {
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          imm_en;
    logic [DW-1:0] imm;
  } cmd_t;

  state_t        state;
  cmd_t          cmd_q;
  logic [DW-1:0] rf [NREG];

  logic          accept;
  logic [DW-1:0] rs1_val;
  logic [DW-1:0] rs2_val;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Register 0 is hard-wired to zero on every read port.
  assign rs1_val  = (cmd_rs1   == '0) ? '0 : rf[cmd_rs1];
  assign rs2_val  = (cmd_q.rs2 == '0) ? '0 : rf[cmd_q.rs2];
  assign dbg_data = (dbg_addr  == '0) ? '0 : rf[dbg_addr];

  // Sequencer FSM. Strobes are registered decodes of the next state, so each
  // one is high for exactly the cycle its state is current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cmd_q  <= '0;
      ALU_OP <= '0;
      Data_A <= '0;
      Data_B <= '0;
      ld_A   <= 1'b0;
      ld_B   <= 1'b0;
      ld_F   <= 1'b0;
      done   <= 1'b0;
      flags  <= '0;
    end else begin
      ld_A <= 1'b0;
      ld_B <= 1'b0;
      ld_F <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q  <= '{rs2: cmd_rs2, rd: cmd_rd, imm_en: cmd_imm_en, imm: cmd_imm};
            ALU_OP <= cmd_op;
            // rf cannot change between accept and LD_A, so reading A now
            // is identical to reading it during LD_A.
            Data_A <= rs1_val;
            ld_A   <= 1'b1;
            state  <= LD_A;
          end
        end
        LD_A: begin
          Data_B <= cmd_q.imm_en ? cmd_q.imm : rs2_val;
          ld_B   <= 1'b1;
          state  <= LD_B;
        end
        LD_B: begin
          ld_F  <= 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          flags <= FR;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Register file: single write port driven by the WB state. Operands were
  // captured earlier, so rd aliasing rs1/rs2 sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (state == WB && cmd_q.rd != '0) begin
      rf[cmd_q.rd] <= F;
    end
  end

  // Load enables and done never overlap.
  a_strobe_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({ld_A, ld_B, ld_F, done}));

  // A strobe is only ever raised while a command is in flight.
  a_strobe_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (ld_A || ld_B || ld_F || done) |-> busy);

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [AW-1:0] cmd_rd;
  logic          cmd_imm_en;
  logic [DW-1:0] cmd_imm;
  logic [3:0]    ALU_OP;
  logic [DW-1:0] Data_A;
  logic [DW-1:0] Data_B;
  logic          ld_A;
  logic          ld_B;
  logic          ld_F;
  logic [DW-1:0] F;
  logic [3:0]    FR;
  logic          done;
  logic [3:0]    flags;
  logic          busy;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural register file and last flags.
  logic [DW-1:0] m_rf [32];
  logic [3:0]    m_flags;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_rd     (cmd_rd),
    .cmd_imm_en (cmd_imm_en),
    .cmd_imm    (cmd_imm),
    .ALU_OP     (ALU_OP),
    .Data_A     (Data_A),
    .Data_B     (Data_B),
    .ld_A       (ld_A),
    .ld_B       (ld_B),
    .ld_F       (ld_F),
    .F          (F),
    .FR         (FR),
    .done       (done),
    .flags      (flags),
    .busy       (busy),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // ALU result and flags {N, Z, C, V}; op 0000 add, 1000 sub, 0001 and,
  // 0010 or, 0011 xor, anything else passes A. Returns {flags, result}.
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        c;
    logic        v;
    w = '0; r = a; c = 1'b0; v = 1'b0;
    case (op)
      4'b0000: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];  v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b1000: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = ~w[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0001: r = a & b;
      4'b0010: r = a | b;
      4'b0011: r = a ^ b;
      default: r = a;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // Behavioural ALU_REG: A/B/F/FR registers with load enables.
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a <= '0; alu_b <= '0; F <= '0; FR <= '0;
    end else begin
      if (ld_A) alu_a <= Data_A;
      if (ld_B) alu_b <= Data_B;
      if (ld_F) {FR, F} <= alu_fn(ALU_OP, alu_a, alu_b);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_flags = '0;
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic imm_en, input logic [31:0] imm);
    logic [35:0] r;
    r = alu_fn(op, m_rf[rs1], imm_en ? imm : m_rf[rs2]);
    if (rd != 5'd0) m_rf[rd] = r[31:0];
    m_flags = r[35:32];
  endtask

  // Offer a command from a negedge; returns at the negedge of cycle 1 (LD_A).
  task automatic send_cmd(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic imm_en, input logic [31:0] imm,
                          output bit acc);
    acc = 1'b0;
    cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_imm_en = imm_en; cmd_imm = imm;
    cmd_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (cmd_ready) acc = 1'b1;
      @(negedge clk);
      if (acc) break;
    end
    cmd_valid = 1'b0;
    // Scramble fields: the in-flight command must not notice.
    cmd_op = 4'($urandom); cmd_rs1 = 5'($urandom); cmd_rs2 = 5'($urandom);
    cmd_rd = 5'($urandom); cmd_imm_en = 1'($urandom); cmd_imm = $urandom;
  endtask

  // Full command: accept, wait (bounded) for done, return in cycle 5.
  task automatic do_cmd(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic imm_en, input logic [31:0] imm,
                        output bit ok);
    bit acc;
    bit saw;
    saw = 1'b0;
    send_cmd(op, rs1, rs2, rd, imm_en, imm, acc);
    if (acc) begin
      for (int n = 0; n < 8; n++) begin
        if (done) begin saw = 1'b1; break; end
        @(negedge clk);
      end
    end
    if (saw) @(negedge clk);
    ok = acc && saw;
    if (ok) model_exec(op, rs1, rs2, rd, imm_en, imm);
  endtask

  task automatic test_reset();
    cmd_valid = 0; cmd_op = 0; cmd_rs1 = 0; cmd_rs2 = 0; cmd_rd = 0; cmd_imm_en = 0; cmd_imm = 0;
    dbg_addr = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, ld_A, ld_B, ld_F, done, flags, ALU_OP} !== 13'd0)
      begin errors++; $display("FAIL reset_ctrl got=%b want=0", {busy, ld_A, ld_B, ld_F, done, flags, ALU_OP}); end
    checks++;
    if ({Data_A, Data_B} !== 64'd0)
      begin errors++; $display("FAIL reset_data got A=%h B=%h want 0", Data_A, Data_B); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk);
  endtask

  task automatic test_first_cmd();
    bit acc;
    logic [3:0] want;
    send_cmd(4'b0000, 5'd0, 5'd0, 5'd1, 1'b1, 32'd3, acc);
    checks++;
    if (!acc) begin errors++; $display("FAIL first_accept got=0 want=1"); end
    for (int k = 1; k <= 4; k++) begin
      want = 4'b1000 >> (k - 1);
      checks++;
      if ({ld_A, ld_B, ld_F, done} !== want)
        begin errors++; $display("FAIL first_strobes cycle=%0d got=%b want=%b", k, {ld_A, ld_B, ld_F, done}, want); end
      checks++;
      if ({busy, cmd_ready} !== 2'b10)
        begin errors++; $display("FAIL first_busy cycle=%0d got=%b want=10", k, {busy, cmd_ready}); end
      if (k == 1) begin
        checks++;
        if ({ALU_OP, Data_A} !== 36'd0) begin errors++; $display("FAIL first_opA got op=%h A=%h want 0/0", ALU_OP, Data_A); end
      end
      if (k == 2) begin
        checks++;
        if (Data_B !== 32'd3) begin errors++; $display("FAIL first_B got=%h want=3", Data_B); end
      end
      @(negedge clk);
    end
    if (acc) model_exec(4'b0000, 5'd0, 5'd0, 5'd1, 1'b1, 32'd3);
    checks++;
    if ({cmd_ready, busy, done} !== 3'b100)
      begin errors++; $display("FAIL first_idle got=%b want=100", {cmd_ready, busy, done}); end
    dbg_addr = 5'd1; #1;
    checks++;
    if (dbg_data !== 32'd3) begin errors++; $display("FAIL first_result got=%h want=3", dbg_data); end
  endtask

  task automatic test_add_sub();
    bit ok1, ok2, ok3, ok4;
    do_cmd(4'b0000, 5'd0, 5'd0, 5'd1, 1'b1, 32'd3, ok1);
    do_cmd(4'b0000, 5'd0, 5'd0, 5'd2, 1'b1, 32'd4, ok2);
    do_cmd(4'b0000, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0, ok3);
    do_cmd(4'b1000, 5'd3, 5'd1, 5'd4, 1'b0, 32'd0, ok4);
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4)) begin errors++; $display("FAIL addsub_handshake got=%b want=1111", {ok1, ok2, ok3, ok4}); end
    dbg_addr = 5'd3; #1;
    checks++;
    if (dbg_data !== 32'd7) begin errors++; $display("FAIL add_result got=%h want=7", dbg_data); end
    dbg_addr = 5'd4; #1;
    checks++;
    if (dbg_data !== 32'd4) begin errors++; $display("FAIL sub_result got=%h want=4", dbg_data); end
    checks++;
    if (flags !== 4'b0010) begin errors++; $display("FAIL sub_flags got=%b want=0010", flags); end
  endtask

  task automatic test_overflow();
    bit ok1, ok2;
    do_cmd(4'b0000, 5'd0, 5'd0, 5'd1, 1'b1, 32'hFFFF_FFFF, ok1);
    do_cmd(4'b0000, 5'd1, 5'd0, 5'd5, 1'b1, 32'd1, ok2);
    dbg_addr = 5'd5; #1;
    checks++;
    if (!(ok1 && ok2) || dbg_data !== 32'd0)
      begin errors++; $display("FAIL wrap_result got=%h ok=%b want=0 ok=11", dbg_data, {ok1, ok2}); end
    checks++;
    if (flags !== 4'b0110 || flags !== m_flags)
      begin errors++; $display("FAIL wrap_flags got=%b want=0110", flags); end
  endtask

  task automatic test_rd_zero();
    bit ok;
    do_cmd(4'b0000, 5'd0, 5'd0, 5'd0, 1'b1, 32'd5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rd0_done got=0 want=1"); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0]; #1;
      checks++;
      if (dbg_data !== m_rf[i]) begin errors++; $display("FAIL rd0_reg x%0d got=%h want=%h", i, dbg_data, m_rf[i]); end
    end
    checks++;
    if (flags !== m_flags) begin errors++; $display("FAIL rd0_flags got=%b want=%b", flags, m_flags); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int done_cyc[$];
    acc_cyc.delete(); done_cyc.delete();
    cmd_op = 4'b0000; cmd_rs1 = 5'd1; cmd_rs2 = 5'd0; cmd_rd = 5'd7; cmd_imm_en = 1'b1; cmd_imm = 32'd10;
    cmd_valid = 1'b1;
    for (int n = 0; n < 14; n++) begin
      if (cmd_valid && cmd_ready) acc_cyc.push_back(n);
      if (done) done_cyc.push_back(n);
      @(posedge clk); #1;
      if (acc_cyc.size() == 1) begin
        cmd_op = 4'b0011; cmd_rs1 = 5'd7; cmd_rs2 = 5'd2; cmd_rd = 5'd8; cmd_imm_en = 1'b0; cmd_imm = 32'hDEAD_BEEF;
      end
      if (acc_cyc.size() == 2) cmd_valid = 1'b0;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (acc_cyc.size() != 2 || acc_cyc[0] != 0 || acc_cyc[1] != 5)
      begin errors++; $display("FAIL b2b_accept got=%p want='{0,5}", acc_cyc); end
    checks++;
    if (done_cyc.size() != 2 || done_cyc[0] != 4 || done_cyc[1] != 9)
      begin errors++; $display("FAIL b2b_done got=%p want='{4,9}", done_cyc); end
    model_exec(4'b0000, 5'd1, 5'd0, 5'd7, 1'b1, 32'd10);
    model_exec(4'b0011, 5'd7, 5'd2, 5'd8, 1'b0, 32'd0);
    for (int i = 7; i <= 8; i++) begin
      dbg_addr = i[4:0]; #1;
      checks++;
      if (dbg_data !== m_rf[i]) begin errors++; $display("FAIL b2b_reg x%0d got=%h want=%h", i, dbg_data, m_rf[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    bit ok;
    int seen;
    send_cmd(4'b0000, 5'd0, 5'd0, 5'd6, 1'b1, 32'd9, acc);
    repeat (2) @(negedge clk);
    checks++;
    if (!acc || ld_F !== 1'b1) begin errors++; $display("FAIL mid_exec got ld_F=%b acc=%b want 1/1", ld_F, acc); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ld_F, flags} !== 7'd0)
      begin errors++; $display("FAIL mid_reset_ctrl got=%b want=0", {busy, done, ld_F, flags}); end
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_done got=%0d pulses want=0", seen); end
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 6; i += 5) begin
      dbg_addr = i[4:0]; #1;
      checks++;
      if (dbg_data !== 32'd0) begin errors++; $display("FAIL mid_rf_clear x%0d got=%h want=0", i, dbg_data); end
    end
    @(negedge clk);
    do_cmd(4'b0000, 5'd0, 5'd0, 5'd6, 1'b1, 32'd9, ok);
    dbg_addr = 5'd6; #1;
    checks++;
    if (!ok || dbg_data !== 32'd9) begin errors++; $display("FAIL mid_recover got=%h ok=%b want=9 ok=1", dbg_data, ok); end
  endtask

  task automatic test_random();
    logic [3:0] ops [5];
    logic [3:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       ie;
    logic [31:0] imm;
    bit ok;
    ops[0] = 4'b0000; ops[1] = 4'b1000; ops[2] = 4'b0001; ops[3] = 4'b0010; ops[4] = 4'b0011;
    for (int t = 0; t < 40; t++) begin
      op  = ops[$urandom_range(4)];
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      ie  = 1'($urandom); imm = $urandom;
      do_cmd(op, rs1, rs2, rd, ie, imm, ok);
      dbg_addr = rd; #1;
      checks++;
      if (!ok || dbg_data !== m_rf[rd] || flags !== m_flags)
        begin errors++; $display("FAIL rand_cmd t=%0d op=%b rd=%0d got=%h/%b ok=%b want=%h/%b", t, op, rd, dbg_data, flags, ok, m_rf[rd], m_flags); end
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0]; #1;
      checks++;
      if (dbg_data !== m_rf[i]) begin errors++; $display("FAIL rand_final x%0d got=%h want=%h", i, dbg_data, m_rf[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_first_cmd();
    test_add_sub();
    test_overflow();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
